// File: rtl/apb_resp_mux_if.sv
// APB bus bundle for apb_resp_mux: the upstream master side (select, enable,
// response) and the fan-out to the downstream slaves.
//
// Handshake: a transfer is selected by psel_i; penable_i marks the access
// phase; the transfer completes on the cycle pready_o is high, and
// prdata_o/psuberr_o are only meaningful on that cycle. Each downstream slave
// completes its access by raising its s_pready_i bit.
interface apb_resp_mux_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int NUM_SLAVES     = 16
);
    logic [15:0]                          pselbus_i;
    logic                                 psel_i;
    logic                                 penable_i;
    logic [APB_DATA_WIDTH-1:0]            prdata_o;
    logic                                 pready_o;
    logic                                 psuberr_o;
    logic [NUM_SLAVES-1:0]                s_psel_o;
    logic                                 s_penable_o;
    logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] s_prdata_i;
    logic [NUM_SLAVES-1:0]                s_pready_i;
    logic [NUM_SLAVES-1:0]                s_pslverr_i;

    // Upstream master and the downstream slaves drive these.
    modport master (
        output pselbus_i, psel_i, penable_i, s_prdata_i, s_pready_i, s_pslverr_i,
        input  prdata_o, pready_o, psuberr_o, s_psel_o, s_penable_o
    );

    // The response mux itself.
    modport slave (
        input  pselbus_i, psel_i, penable_i, s_prdata_i, s_pready_i, s_pslverr_i,
        output prdata_o, pready_o, psuberr_o, s_psel_o, s_penable_o
    );
endinterface

// File: rtl/apb_resp_mux.sv
// APB response multiplexer: decodes a one-hot slave select, fans PSEL/PENABLE
// out to the slaves, returns the selected slave's response, and turns decode
// errors and stuck slaves (timeout) into error completions with ERR_DATA.
// Saturating status counters record decode errors and timeouts.
module apb_resp_mux #(
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        NUM_SLAVES     = 16,
    parameter int                        TIMEOUT_CYCLES = 256,
    parameter logic [APB_DATA_WIDTH-1:0] ERR_DATA       = APB_DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic             pclk_i,
    input  logic             prstn_i,
    apb_resp_mux_if.slave    bus,
    input  logic             clr_cnt_i,
    output logic [7:0]       decerr_cnt_o,
    output logic [7:0]       timeout_cnt_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Bits of pselbus_i that map onto real slave ports.
    localparam logic [15:0] LOW_MASK = 16'((17'd1 << NUM_SLAVES) - 17'd1);
    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [15:0]               wait_cnt_q;
    logic [15:0]               low_sel;
    logic                      dec_valid;
    logic                      in_access;
    logic                      timeout_hit;
    logic [APB_DATA_WIDTH-1:0] sel_data;
    logic                      sel_ready;
    logic                      sel_err;
    logic [NUM_SLAVES-1:0]     s_psel;
    logic                      pready;

    // Decode is valid only for exactly one select bit inside the slave range.
    assign low_sel   = bus.pselbus_i & LOW_MASK;
    assign dec_valid = (low_sel != 16'd0)
                    && ((low_sel & (low_sel - 16'd1)) == 16'd0)
                    && ((bus.pselbus_i & ~LOW_MASK) == 16'd0);

    // Pick the response of the selected slave (select is one-hot when used).
    always_comb begin
        sel_data  = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (low_sel[i]) begin
                sel_data  = bus.s_prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                sel_ready = bus.s_pready_i[i];
                sel_err   = bus.s_pslverr_i[i];
            end
        end
    end

    // A dropped psel_i ends the access immediately, so it never responds.
    assign in_access   = prstn_i && bus.psel_i && (state_q == ACCESS);
    assign timeout_hit = in_access && dec_valid && !sel_ready && (wait_cnt_q == WAIT_MAX);

    assign s_psel          = (prstn_i && bus.psel_i && dec_valid) ? low_sel[NUM_SLAVES-1:0] : '0;
    assign bus.s_psel_o    = s_psel;
    assign bus.s_penable_o = prstn_i && bus.penable_i && (|s_psel);

    // Response to the master: decode error, slave response, or timeout error.
    always_comb begin
        pready        = 1'b0;
        bus.psuberr_o = 1'b0;
        bus.prdata_o  = '0;
        if (in_access) begin
            if (!dec_valid) begin
                pready        = 1'b1;
                bus.psuberr_o = 1'b1;
                bus.prdata_o  = ERR_DATA;
            end else if (sel_ready) begin
                pready        = 1'b1;
                bus.psuberr_o = sel_err;
                bus.prdata_o  = sel_data;
            end else if (timeout_hit) begin
                pready        = 1'b1;
                bus.psuberr_o = 1'b1;
                bus.prdata_o  = ERR_DATA;
            end
        end
    end
    assign bus.pready_o = pready;

    // Next-state logic; losing psel_i always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!bus.psel_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!bus.penable_i) state_d = SETUP;
                SETUP:   if (bus.penable_i)  state_d = ACCESS;
                ACCESS:  if (pready)         state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Wait counter: zero outside ACCESS, counts ACCESS cycles without completion.
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i)                              wait_cnt_q <= 16'd0;
        else if (state_q != ACCESS || !bus.psel_i) wait_cnt_q <= 16'd0;
        else if (!pready)                          wait_cnt_q <= wait_cnt_q + 16'd1;
    end

    // Saturating status counters; a clear beats a same-cycle increment.
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            decerr_cnt_o  <= 8'd0;
            timeout_cnt_o <= 8'd0;
        end else if (clr_cnt_i) begin
            decerr_cnt_o  <= 8'd0;
            timeout_cnt_o <= 8'd0;
        end else begin
            if (in_access && !dec_valid && decerr_cnt_o != 8'hFF)
                decerr_cnt_o <= decerr_cnt_o + 8'd1;
            if (timeout_hit && timeout_cnt_o != 8'hFF)
                timeout_cnt_o <= timeout_cnt_o + 8'd1;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_apb_resp_mux.sv
// Directed/random bench for apb_resp_mux with an 8-slave, 4-cycle-timeout
// configuration. Expected responses are queued when a transfer is launched
// and popped when the DUT completes it.
module tb_apb_resp_mux;
    localparam int W  = 32;
    localparam int NS = 8;
    localparam int TO = 4;
    localparam logic [W-1:0] ERR = 32'hDEAD_BEEF;

    logic       pclk_i;
    logic       prstn_i;
    logic       clr_cnt_i;
    logic [7:0] decerr_cnt_o;
    logic [7:0] timeout_cnt_o;
    logic       busy_o;
    logic [1:0] state_o;

    apb_resp_mux_if #(.APB_DATA_WIDTH(W), .NUM_SLAVES(NS)) bus_if ();

    apb_resp_mux #(
        .APB_DATA_WIDTH(W),
        .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA(ERR)
    ) dut (
        .pclk_i(pclk_i),
        .prstn_i(prstn_i),
        .bus(bus_if),
        .clr_cnt_i(clr_cnt_i),
        .decerr_cnt_o(decerr_cnt_o),
        .timeout_cnt_o(timeout_cnt_o),
        .busy_o(busy_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- slave data model ----------------
    logic [W-1:0] sdata [NS];
    always_comb begin
        for (int i = 0; i < NS; i++) bus_if.s_prdata_i[i*W +: W] = sdata[i];
    end

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];   // {psuberr, prdata}
    int total = 0;
    int bad   = 0;
    int dec_m = 0;
    int to_m  = 0;
    bit clr_active = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_decerr"},  64'(decerr_cnt_o),  64'(dec_m));
        check({tag, "_timeout"}, 64'(timeout_cnt_o), 64'(to_m));
    endtask

    // ---------------- driver ----------------
    // One full transfer; the slave raises ready in ACCESS cycle ready_at
    // (values above TO mean the slave never answers in time).
    task automatic do_xfer(input logic [15:0] sel_bus, input int ready_at, input logic slverr);
        logic         valid;
        int           idx;
        int           exp_lat;
        logic [W:0]   exp_v;
        logic [W:0]   got;
        bit           done;

        valid = ($countones(sel_bus[NS-1:0]) == 1) && (sel_bus[15:NS] == '0);
        idx = 0;
        for (int i = 0; i < NS; i++) if (sel_bus[i]) idx = i;
        if (!valid) begin
            exp_v = {1'b1, ERR}; exp_lat = 1;
            if (clr_active) dec_m = 0; else if (dec_m < 255) dec_m++;
        end else if (ready_at <= TO) begin
            exp_v = {slverr, sdata[idx]}; exp_lat = ready_at;
            if (clr_active) begin dec_m = 0; to_m = 0; end
        end else begin
            exp_v = {1'b1, ERR}; exp_lat = TO;
            if (clr_active) to_m = 0; else if (to_m < 255) to_m++;
        end
        if (clr_active) begin dec_m = 0; to_m = 0; end
        exp_q.push_back(exp_v);

        @(negedge pclk_i);
        bus_if.pselbus_i   = sel_bus;
        bus_if.psel_i      = 1'b1;
        bus_if.penable_i   = 1'b0;
        bus_if.s_pready_i  = '0;
        bus_if.s_pslverr_i = {NS{slverr}};
        @(negedge pclk_i);
        bus_if.penable_i = 1'b1;
        #1;
        check("setup_pready", 64'(bus_if.pready_o), 64'd0);
        check("setup_psel", 64'(bus_if.s_psel_o), valid ? 64'(sel_bus[NS-1:0]) : 64'd0);
        check("setup_penable", 64'(bus_if.s_penable_o), 64'(valid));
        check("setup_busy", 64'(busy_o), 64'd1);

        done = 1'b0;
        for (int cyc = 1; cyc <= 12 && !done; cyc++) begin
            @(negedge pclk_i);
            bus_if.s_pready_i = (cyc == ready_at) ? {NS{1'b1}} : '0;
            #1;
            if (bus_if.pready_o === 1'b1) begin
                done = 1'b1;
                got  = {bus_if.psuberr_o, bus_if.prdata_o};
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("resp_data", 64'(got[W-1:0]), 64'(exp_v[W-1:0]));
                    check("resp_err",  64'(got[W]),     64'(exp_v[W]));
                end
                check("resp_latency", 64'(cyc), 64'(exp_lat));
            end
        end
        if (!done) begin
            total++;
            bad++;
            $error("FAIL xfer_bound: no pready_o within 12 cycles, required completion at %0d", exp_lat);
            void'(exp_q.pop_front());
        end

        @(negedge pclk_i);
        bus_if.psel_i     = 1'b0;
        bus_if.penable_i  = 1'b0;
        bus_if.s_pready_i = '0;
        #1;
        check("post_busy", 64'(busy_o), 64'd0);
        check_counters("post");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pready"},  64'(bus_if.pready_o),    64'd0);
        check({tag, "_psuberr"}, 64'(bus_if.psuberr_o),   64'd0);
        check({tag, "_penable"}, 64'(bus_if.s_penable_o), 64'd0);
        check({tag, "_psel"},    64'(bus_if.s_psel_o),    64'd0);
        check({tag, "_prdata"},  64'(bus_if.prdata_o),    64'd0);
        check({tag, "_busy"},    64'(busy_o),             64'd0);
        check({tag, "_decerr"},  64'(decerr_cnt_o),       64'd0);
        check({tag, "_timeout"}, 64'(timeout_cnt_o),      64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NS; i++) sdata[i] = 32'hA000_0000 + 32'(i);
        sdata[3] = 32'h1234_5678;
        clr_cnt_i = 1'b0;
        // Reset with an active-looking bus to prove outputs are forced low.
        prstn_i            = 1'b0;
        bus_if.pselbus_i   = 16'h0008;
        bus_if.psel_i      = 1'b1;
        bus_if.penable_i   = 1'b1;
        bus_if.s_pready_i  = '1;
        bus_if.s_pslverr_i = '1;
        repeat (3) @(negedge pclk_i);
        #1;
        check_reset_outputs("reset");
        bus_if.psel_i     = 1'b0;
        bus_if.penable_i  = 1'b0;
        bus_if.s_pready_i = '0;
        @(negedge pclk_i);
        prstn_i = 1'b1;
        @(negedge pclk_i);

        do_xfer(16'h0008, 1, 1'b0);      // slave 3, zero wait
        do_xfer(16'h0000, 1, 1'b0);      // no select
        do_xfer(16'h0100, 1, 1'b0);      // select above slave range
        do_xfer(16'h0003, 1, 1'b0);      // two-hot
        do_xfer(16'h0001, 99, 1'b0);     // slave 0 never ready -> timeout
        do_xfer(16'h0001, TO, 1'b1);     // ready on timeout cycle wins
        do_xfer(16'h0080, 3, 1'b0);      // slave 7, two wait states

        for (int n = 0; n < 8; n++) begin
            int s;
            s = $urandom_range(0, NS-1);
            sdata[s] = $urandom;
            do_xfer(16'(1 << s), $urandom_range(1, TO+2), 1'($urandom_range(0, 1)));
        end

        // psel_i dropped after two stalled ACCESS cycles.
        @(negedge pclk_i);
        bus_if.pselbus_i = 16'h0004;
        bus_if.psel_i    = 1'b1;
        bus_if.penable_i = 1'b0;
        @(negedge pclk_i);
        bus_if.penable_i = 1'b1;
        repeat (2) @(negedge pclk_i);
        bus_if.psel_i    = 1'b0;
        bus_if.penable_i = 1'b0;
        #1;
        check("drop_pready", 64'(bus_if.pready_o), 64'd0);
        @(negedge pclk_i);
        #1;
        check("drop_busy", 64'(busy_o), 64'd0);
        check_counters("drop");
        do_xfer(16'h0004, TO, 1'b0);     // wait counter must have restarted

        // Decode-error counter saturation, then clear.
        for (int n = 0; n < 300; n++) do_xfer(16'h0000, 1, 1'b0);
        check("sat_decerr", 64'(decerr_cnt_o), 64'd255);
        @(negedge pclk_i);
        clr_cnt_i = 1'b1;
        @(negedge pclk_i);
        clr_cnt_i = 1'b0;
        dec_m = 0; to_m = 0;
        #1;
        check_counters("clr");

        // Clear held across a decode-error completion.
        clr_active = 1'b1;
        clr_cnt_i  = 1'b1;
        do_xfer(16'h0000, 1, 1'b0);
        clr_cnt_i  = 1'b0;
        clr_active = 1'b0;
        do_xfer(16'h0000, 1, 1'b0);      // leaves decerr at 1 before reset

        // Reset in the 3rd ACCESS cycle of a stalled transfer.
        @(negedge pclk_i);
        bus_if.pselbus_i = 16'h0001;
        bus_if.psel_i    = 1'b1;
        bus_if.penable_i = 1'b0;
        @(negedge pclk_i);
        bus_if.penable_i = 1'b1;
        repeat (3) @(negedge pclk_i);
        prstn_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge pclk_i);
        #1;
        check_reset_outputs("midrst_hold");
        bus_if.psel_i    = 1'b0;
        bus_if.penable_i = 1'b0;
        prstn_i = 1'b1;
        dec_m = 0; to_m = 0;
        @(negedge pclk_i);
        do_xfer(16'h0008, 1, 1'b0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_resp_mux.md
APB_RESP_MUX -- requirements
Module: apb_resp_mux

Interface
REQ-001 Parameter APB_DATA_WIDTH, default 32, width of read data paths.
REQ-002 Parameter NUM_SLAVES, default 16, range 1..16, number of downstream slave ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, range 2..65535, maximum access-phase cycles before forced error completion.
REQ-004 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on decode error or timeout.
REQ-005 pclk_i  input  1  clock, all state on rising edge.
REQ-006 prstn_i  input  1  reset, asynchronous, active-low.
REQ-007 pselbus_i  input  16  per-slave select from upstream APB master.
REQ-008 psel_i  input  1  upstream PSEL.
REQ-009 penable_i  input  1  upstream PENABLE.
REQ-010 prdata_o  output  APB_DATA_WIDTH  read data to master.
REQ-011 pready_o  output  1  transfer completion to master.
REQ-012 psuberr_o  output  1  error response to master.
REQ-013 s_psel_o  output  NUM_SLAVES  per-slave PSEL.
REQ-014 s_penable_o  output  1  PENABLE broadcast to slaves.
REQ-015 s_prdata_i  input  NUM_SLAVES*APB_DATA_WIDTH  packed slave read data, slave i at bits [i*W +: W].
REQ-016 s_pready_i  input  NUM_SLAVES  per-slave PREADY.
REQ-017 s_pslverr_i  input  NUM_SLAVES  per-slave PSLVERR.
REQ-018 clr_cnt_i  input  1  synchronous clear of status counters.
REQ-019 decerr_cnt_o  output  8  saturating count of decode errors.
REQ-020 timeout_cnt_o  output  8  saturating count of timeouts.
REQ-021 busy_o  output  1  high while state is SETUP or ACCESS.

Function
REQ-022 State machine SHALL have states IDLE, SETUP, ACCESS; encoding is implementation-defined.
REQ-023 Transitions: IDLE->SETUP on psel_i&~penable_i; SETUP->ACCESS on psel_i&penable_i; ACCESS->IDLE on pready_o; any state->IDLE on ~psel_i.
REQ-024 Decode: valid when pselbus_i[NUM_SLAVES-1:0] is exactly one-hot and pselbus_i[15:NUM_SLAVES] is zero; otherwise decode error.
REQ-025 s_psel_o[i] SHALL equal pselbus_i[i]&psel_i for valid decode, all zeros on decode error.
REQ-026 s_penable_o SHALL equal penable_i & (any s_psel_o bit).
REQ-027 ACCESS with valid decode: pready_o=s_pready_i[sel] | timeout_hit; prdata_o=s_prdata_i[sel] and psuberr_o=s_pslverr_i[sel] when slave ready, else ERR_DATA and 1 on timeout_hit.
REQ-028 ACCESS with decode error: pready_o=1, psuberr_o=1, prdata_o=ERR_DATA in the first ACCESS cycle (zero wait states).
REQ-029 Outside ACCESS: pready_o=0, psuberr_o=0, prdata_o=0.
REQ-030 Wait counter (16-bit) SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready_o low.
REQ-031 timeout_hit SHALL assert when wait counter == TIMEOUT_CYCLES-1 and selected slave pready low; completion then occurs in the TIMEOUT_CYCLES-th ACCESS cycle.
REQ-032 Slave pready in the same cycle as timeout_hit: slave response wins; timeout_cnt_o unchanged.
REQ-033 decerr_cnt_o increments by 1 per decode-error completion; timeout_cnt_o by 1 per timeout completion; both saturate at 255.
REQ-034 clr_cnt_i SHALL zero both counters next edge; clear wins over a simultaneous increment.
REQ-035 psel_i dropping mid-ACCESS SHALL return to IDLE, clear wait counter, count nothing.

Reset
REQ-036 While prstn_i low: state IDLE, wait counter 0, decerr_cnt_o=0, timeout_cnt_o=0, busy_o=0.
REQ-037 While prstn_i low: pready_o, psuberr_o, s_penable_o, s_psel_o, prdata_o SHALL be 0 regardless of inputs.
REQ-038 Reset asserted mid-ACCESS SHALL abort the transfer without counter update; first transfer after release begins from IDLE.

Verification
REQ-039 Read slave 3 (pselbus_i=16'h0008), s_pready_i[3] high in first ACCESS cycle, data 32'h1234_5678 -> pready_o=1 same cycle, prdata_o=32'h1234_5678, psuberr_o=0, counters 0.
REQ-040 pselbus_i=16'h0000 with psel_i/penable_i -> s_psel_o=0, pready_o=1, psuberr_o=1, prdata_o=32'hDEAD_BEEF in first ACCESS cycle, decerr_cnt_o=1.
REQ-041 TIMEOUT_CYCLES=4, slave 0 never ready -> pready_o=1, psuberr_o=1 in 4th ACCESS cycle, timeout_cnt_o=1.
REQ-042 TIMEOUT_CYCLES=4, slave 0 ready in 4th ACCESS cycle with s_pslverr_i[0]=1 -> slave data returned, psuberr_o=1, timeout_cnt_o=0.
REQ-043 300 decode-error transfers -> decerr_cnt_o=255; clr_cnt_i pulse -> 0 next cycle.
REQ-044 prstn_i low for 2 cycles during 3rd ACCESS cycle -> all outputs 0 during reset, next transfer completes normally, counters 0.
